// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the cache row store and the L1 cache controller:
//   - default geometry (sets, ways, tag and line widths)
//   - derived field widths (way field, full row)
//   - row layout helpers: way slice base, valid/dirty/tag offsets, LRU base
//   - FSM state type of the row store's init/flush engine
// ---------------------------------------------------------------------------
package cache_pkg;

  // Default geometry
  localparam int unsigned DEF_SETS   = 32'd128;
  localparam int unsigned DEF_WAYS   = 32'd2;
  localparam int unsigned DEF_TAG_W  = 32'd21;
  localparam int unsigned DEF_LINE_W = 32'd128;

  // Init/flush engine states. INIT and FLUSH share the same set walk;
  // only FLUSH reports completion.
  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FLUSH = 2'd2
  } cache_state_e;

  // Per-way field width: valid + dirty + tag + line data
  function automatic int calc_way_w(input int tag_w, input int line_w);
    return 32'sd2 + tag_w + line_w;
  endfunction

  // Row width: tree-PLRU field (ways-1 bits) on top of all way fields
  function automatic int calc_row_w(input int ways, input int way_w);
    return (ways - 32'sd1) + ways * way_w;
  endfunction

  // Lowest row bit of way w
  function automatic int way_slice_lo(input int w, input int way_w);
    return w * way_w;
  endfunction

  // Bit offsets inside one way field
  function automatic int valid_off(input int way_w);
    return way_w - 32'sd1;
  endfunction

  function automatic int dirty_off(input int way_w);
    return way_w - 32'sd2;
  endfunction

  function automatic int tag_lo_off(input int line_w);
    return line_w;
  endfunction

  // Lowest row bit of the LRU field (it sits directly above the last way)
  function automatic int lru_lo(input int ways, input int way_w);
    return ways * way_w;
  endfunction

  localparam int unsigned DEF_WAY_W = calc_way_w(DEF_TAG_W, DEF_LINE_W);
  localparam int unsigned DEF_ROW_W = calc_row_w(DEF_WAYS, DEF_WAY_W);

endpackage

// File: rtl/cache_row_ram.sv
// ---------------------------------------------------------------------------
// cache_row_ram
// Generic DEPTH x WIDTH single-port synchronous RAM with per-bit write
// enable and a registered read port. A write and a read capture on the same
// cycle return the post-write word (write-first). The output register only
// loads when i_re is high, so it holds its value across write-only cycles.
// The storage array has no reset; only the output register does.
//
// Ports:
//   clk      in   clock
//   rst_n    in   async active-low reset (output register only)
//   i_we     in   write the addressed word through i_bwe
//   i_re     in   capture the addressed word into o_rdata
//   i_addr   in   word address
//   i_bwe    in   per-bit write enable
//   i_wdata  in   write data
//   o_rdata  out  registered read data
// ---------------------------------------------------------------------------
module cache_row_ram #(
  parameter int unsigned DEPTH  = 32'd128,
  parameter int unsigned WIDTH  = 32'd303,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WIDTH-1:0]  i_bwe,
  input  logic [WIDTH-1:0]  i_wdata,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;
  logic [WIDTH-1:0] w_old;
  logic [WIDTH-1:0] w_merged;

  assign w_old    = r_mem[i_addr];
  // Masked bits take new data, the rest keep the stored word
  assign w_merged = (w_old & ~i_bwe) | (i_wdata & i_bwe);

  // Storage array write
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= w_merged;
    end
  end

  // Registered read port, write-first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= i_we ? w_merged : w_old;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/cache_set_ram.sv
// ---------------------------------------------------------------------------
// cache_set_ram
// N-way set-associative cache row store. Each row holds the tree-PLRU field
// and WAYS x {valid, dirty, tag, line}. Single 1RW port with 1-cycle
// registered, write-first read. After reset the engine zeroes every set
// (INIT); a flush_req pulse in IDLE repeats that walk (FLUSH) and signals
// flush_done when the last set is cleared.
//
// Ports:
//   clk           in   clock
//   rst_n         in   async active-low reset
//   req_valid     in   request, accepted when ready=1
//   req_set       in   set index
//   req_we        in   request writes the row
//   req_way_mask  in   per-way write enable (qualified by req_we)
//   req_lru_we    in   LRU field write enable (qualified by req_we)
//   req_wdata     in   write row, same layout as rdata
//   ready         out  idle and accepting requests
//   rvalid        out  rdata valid, one cycle after an accepted request
//   rdata         out  registered row read data (holds when rvalid=0)
//   flush_req     in   pulse: clear the whole array
//   flush_done    out  pulse at flush completion
// ---------------------------------------------------------------------------
module cache_set_ram
  import cache_pkg::*;
#(
  parameter int unsigned SETS   = DEF_SETS,
  parameter int unsigned WAYS   = DEF_WAYS,
  parameter int unsigned TAG_W  = DEF_TAG_W,
  parameter int unsigned LINE_W = DEF_LINE_W,
  localparam int unsigned SET_W = $clog2(SETS),
  localparam int unsigned WAY_W = calc_way_w(TAG_W, LINE_W),
  localparam int unsigned ROW_W = calc_row_w(WAYS, WAY_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [SET_W-1:0] req_set,
  input  logic             req_we,
  input  logic [WAYS-1:0]  req_way_mask,
  input  logic             req_lru_we,
  input  logic [ROW_W-1:0] req_wdata,
  output logic             ready,
  output logic             rvalid,
  output logic [ROW_W-1:0] rdata,
  input  logic             flush_req,
  output logic             flush_done
);

  cache_state_e     r_state;
  cache_state_e     w_next_state;
  logic [SET_W-1:0] r_cnt;
  logic [SET_W-1:0] w_cnt_next;
  logic             w_cnt_last;

  logic             r_ready;
  logic             r_rvalid;
  logic             r_flush_done;
  logic             w_accept;

  logic             w_ram_we;
  logic             w_ram_re;
  logic [SET_W-1:0] w_ram_addr;
  logic [ROW_W-1:0] w_ram_bwe;
  logic [ROW_W-1:0] w_ram_wdata;
  logic [ROW_W-1:0] w_ram_rdata;
  logic [ROW_W-1:0] w_bwe_req;

  assign w_cnt_last = (r_cnt == SET_W'(SETS - 32'd1));
  assign w_accept   = req_valid & r_ready;

  // State and walk-counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state and counter logic; the counter only restarts through a
  // state transition, so it never runs past the last set.
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_INIT, ST_FLUSH: begin
        if (w_cnt_last) begin
          w_next_state = ST_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_next_state = r_state;
          w_cnt_next   = r_cnt + SET_W'(1);
        end
      end
      ST_IDLE: begin
        // A request on the same cycle is still serviced by the RAM controls
        if (flush_req) begin
          w_next_state = ST_FLUSH;
          w_cnt_next   = '0;
        end else begin
          w_next_state = ST_IDLE;
          w_cnt_next   = r_cnt;
        end
      end
      default: begin
        w_next_state = ST_INIT;
        w_cnt_next   = '0;
      end
    endcase
  end

  // RAM control decode: walk writes zero rows, IDLE forwards requests
  always_comb begin
    // Expand the way mask to whole way fields plus the LRU field
    w_bwe_req = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      w_bwe_req[way_slice_lo(w, int'(WAY_W)) +: WAY_W] = {WAY_W{req_way_mask[w]}};
    end
    w_bwe_req[lru_lo(int'(WAYS), int'(WAY_W)) +: (WAYS-1)] = {(WAYS-1){req_lru_we}};

    w_ram_we    = 1'b0;
    w_ram_re    = 1'b0;
    w_ram_addr  = '0;
    w_ram_bwe   = '0;
    w_ram_wdata = '0;
    case (r_state)
      ST_INIT, ST_FLUSH: begin
        w_ram_we    = 1'b1;
        w_ram_re    = 1'b0;
        w_ram_addr  = r_cnt;
        w_ram_bwe   = '1;
        w_ram_wdata = '0;
      end
      ST_IDLE: begin
        w_ram_we    = w_accept & req_we;
        w_ram_re    = w_accept;
        w_ram_addr  = req_set;
        w_ram_bwe   = w_bwe_req;
        w_ram_wdata = req_wdata;
      end
      default: begin
        w_ram_we    = 1'b0;
        w_ram_re    = 1'b0;
        w_ram_addr  = '0;
        w_ram_bwe   = '0;
        w_ram_wdata = '0;
      end
    endcase
  end

  // Registered status outputs; ready follows the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready      <= 1'b0;
      r_rvalid     <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      r_ready      <= (w_next_state == ST_IDLE);
      r_rvalid     <= w_accept;
      r_flush_done <= (r_state == ST_FLUSH) && w_cnt_last;
    end
  end

  cache_row_ram #(
    .DEPTH (SETS),
    .WIDTH (ROW_W),
    .ADDR_W(SET_W)
  ) u_row_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_we   (w_ram_we),
    .i_re   (w_ram_re),
    .i_addr (w_ram_addr),
    .i_bwe  (w_ram_bwe),
    .i_wdata(w_ram_wdata),
    .o_rdata(w_ram_rdata)
  );

  assign ready      = r_ready;
  assign rvalid     = r_rvalid;
  assign rdata      = w_ram_rdata;
  assign flush_done = r_flush_done;

endmodule

// File: tb/tb_cache_set_ram.sv
// ---------------------------------------------------------------------------
// tb_cache_set_ram
// Self-checking bench for cache_set_ram (default geometry: 128 sets, 2 ways,
// 21-bit tag, 128-bit line, 303-bit row). Directed table of accesses with
// hand-built expected rows, randomized accesses against an array model,
// and hand-written flush / reset-during-flush sequences.
// ---------------------------------------------------------------------------
module tb_cache_set_ram;

  localparam int SETS   = 128;
  localparam int WAYS   = 2;
  localparam int WAY_W  = 151;
  localparam int ROW_W  = 303;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic [6:0]       req_set;
  logic             req_we;
  logic [1:0]       req_way_mask;
  logic             req_lru_we;
  logic [ROW_W-1:0] req_wdata;
  logic             ready;
  logic             rvalid;
  logic [ROW_W-1:0] rdata;
  logic             flush_req;
  logic             flush_done;

  int n_tests = 0;
  int n_fail  = 0;
  int fd_count = 0;

  logic [ROW_W-1:0] model [SETS];

  cache_set_ram dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_set     (req_set),
    .req_we      (req_we),
    .req_way_mask(req_way_mask),
    .req_lru_we  (req_lru_we),
    .req_wdata   (req_wdata),
    .ready       (ready),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .flush_req   (flush_req),
    .flush_done  (flush_done)
  );

  always #5 clk = ~clk;

  // Count flush_done pulses, sampled mid-cycle
  always @(negedge clk) if (flush_done === 1'b1) fd_count++;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [6:0]       set;
    logic             we;
    logic [1:0]       mask;
    logic             lru_we;
    logic [ROW_W-1:0] wdata;
    logic [ROW_W-1:0] exp;
  } vec_t;

  function automatic logic [WAY_W-1:0] mk_way(input logic v, input logic d,
                                              input logic [20:0] tag,
                                              input logic [127:0] data);
    return {v, d, tag, data};
  endfunction

  function automatic logic [ROW_W-1:0] mk_row(input logic lru,
                                              input logic [WAY_W-1:0] w1,
                                              input logic [WAY_W-1:0] w0);
    return {lru, w1, w0};
  endfunction

  function automatic vec_t mkv(input int s, input logic we, input logic [1:0] m,
                               input logic lw, input logic [ROW_W-1:0] wd,
                               input logic [ROW_W-1:0] ex);
    vec_t v;
    v.set = 7'(s); v.we = we; v.mask = m; v.lru_we = lw; v.wdata = wd; v.exp = ex;
    return v;
  endfunction

  function automatic logic [ROW_W-1:0] rand_row();
    logic [ROW_W-1:0] v;
    for (int k = 0; k < ROW_W; k++) v[k] = 1'($urandom_range(1, 0));
    return v;
  endfunction

  task automatic chk(input string nm, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Reference: a write replaces whole masked way fields and the LRU bit
  task automatic model_access(input int s, input logic we, input logic [1:0] m,
                              input logic lw, input logic [ROW_W-1:0] wd,
                              output logic [ROW_W-1:0] row);
    if (we) begin
      for (int w = 0; w < WAYS; w++)
        if (m[w]) model[s][w*WAY_W +: WAY_W] = wd[w*WAY_W +: WAY_W];
      if (lw) model[s][ROW_W-1] = wd[ROW_W-1];
    end
    row = model[s];
  endtask

  task automatic model_clear();
    for (int i = 0; i < SETS; i++) model[i] = '0;
  endtask

  task automatic issue(input logic [6:0] s, input logic we, input logic [1:0] m,
                       input logic lw, input logic [ROW_W-1:0] wd, input logic fl);
    req_valid = 1'b1; req_set = s; req_we = we; req_way_mask = m;
    req_lru_we = lw; req_wdata = wd; flush_req = fl;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_way_mask = 2'b00;
    req_lru_we = 1'b0; flush_req = 1'b0;
  endtask

  // Clock edges until ready rises, bounded
  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (ready !== 1'b1 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  vec_t vecs [11];
  logic [ROW_W-1:0] row_a, row_b, row_c, row_d, row_e, exp_row, last_rdata;
  logic [WAY_W-1:0] way0_a, way1_a, way1_b;
  int cyc, fd_before;

  initial begin
    // ---------------- directed table ----------------
    way0_a = mk_way(1'b1, 1'b0, 21'h1ABCD, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
    way1_a = mk_way(1'b1, 1'b1, 21'h00042, 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555);
    way1_b = mk_way(1'b1, 1'b1, 21'h0BEEF, 128'hDEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD);
    row_a  = mk_row(1'b1, way1_a, way0_a);
    // way1 update, way0 and LRU bits carry junk that must not land
    row_b  = mk_row(1'b0, way1_b, mk_way(1'b0, 1'b1, 21'h155555, 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000));
    row_c  = mk_row(1'b1, mk_way(1'b1, 1'b0, 21'h1FFFF, 128'hA5A5), mk_way(1'b0, 1'b1, 21'h00001, 128'h5A5A));
    row_d  = mk_row(1'b0, mk_way(1'b0, 1'b0, 21'h12345, 128'h7777), mk_way(1'b1, 1'b1, 21'h1F00F, 128'h8888));

    vecs[0]  = mkv(5,   1'b0, 2'b00, 1'b0, '0,    '0);
    vecs[1]  = mkv(3,   1'b1, 2'b11, 1'b1, row_a, row_a);
    vecs[2]  = mkv(3,   1'b0, 2'b00, 1'b0, '0,    row_a);
    vecs[3]  = mkv(3,   1'b1, 2'b10, 1'b0, row_b, mk_row(1'b1, way1_b, way0_a));
    vecs[4]  = mkv(3,   1'b0, 2'b00, 1'b0, '0,    mk_row(1'b1, way1_b, way0_a));
    vecs[5]  = mkv(127, 1'b1, 2'b11, 1'b1, row_c, row_c);
    vecs[6]  = mkv(0,   1'b1, 2'b11, 1'b1, row_d, row_d);
    vecs[7]  = mkv(127, 1'b0, 2'b00, 1'b0, '0,    row_c);
    vecs[8]  = mkv(0,   1'b0, 2'b00, 1'b0, '0,    row_d);
    vecs[9]  = mkv(127, 1'b1, 2'b00, 1'b0, row_b, row_c);
    vecs[10] = mkv(0,   1'b0, 2'b11, 1'b1, row_b, row_d);

    // ---------------- reset and INIT ----------------
    rst_n = 1'b0; req_valid = 1'b0; req_set = '0; req_we = 1'b0;
    req_way_mask = 2'b00; req_lru_we = 1'b0; req_wdata = '0; flush_req = 1'b0;
    model_clear();
    #23;
    chk("reset_ready", ready, '0);
    chk("reset_rvalid", rvalid, '0);
    chk("reset_rdata", rdata, '0);
    chk("reset_flush_done", flush_done, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_ready(cyc);
    chk("init_ready_cycles", ROW_W'(cyc), ROW_W'(SETS));

    // ---------------- table ----------------
    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].set, vecs[i].we, vecs[i].mask, vecs[i].lru_we, vecs[i].wdata, 1'b0);
      model_access(int'(vecs[i].set), vecs[i].we, vecs[i].mask, vecs[i].lru_we, vecs[i].wdata, exp_row);
      chk($sformatf("vec%0d_rvalid", i), rvalid, 1);
      chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp);
    end
    // rdata holds, rvalid drops on an idle cycle
    @(posedge clk); #1;
    chk("idle_rvalid", rvalid, '0);
    chk("idle_rdata_hold", rdata, vecs[10].exp);
    last_rdata = vecs[10].exp;

    // ---------------- randomized accesses vs model ----------------
    for (int n = 0; n < 400; n++) begin
      logic [6:0]  s;
      logic        we, lw;
      logic [1:0]  m;
      logic [ROW_W-1:0] wd;
      s  = ($urandom_range(1, 0) == 1) ? 7'($urandom_range(7, 0)) : 7'($urandom_range(127, 0));
      we = 1'($urandom_range(1, 0));
      m  = 2'($urandom_range(3, 0));
      lw = 1'($urandom_range(1, 0));
      wd = rand_row();
      if ($urandom_range(3, 0) == 0) begin
        req_valid = 1'b0; req_set = s; req_we = we; req_way_mask = m;
        req_lru_we = lw; req_wdata = wd;
        @(posedge clk); #1;
        chk("rand_gap_rvalid", rvalid, '0);
        chk("rand_gap_rdata_hold", rdata, last_rdata);
      end else begin
        model_access(int'(s), we, m, lw, wd, exp_row);
        issue(s, we, m, lw, wd, 1'b0);
        chk("rand_rvalid", rvalid, 1);
        chk($sformatf("rand_rdata_set%0d", s), rdata, exp_row);
        last_rdata = exp_row;
      end
    end
    req_we = 1'b0; req_way_mask = 2'b00; req_lru_we = 1'b0;

    // ---------------- flush, coincident with a write ----------------
    row_e = rand_row();
    fd_before = fd_count;
    issue(7'd10, 1'b1, 2'b11, 1'b1, row_e, 1'b1);
    chk("flush_coincident_rvalid", rvalid, 1);
    chk("flush_coincident_rdata", rdata, row_e);
    chk("flush_ready_drop", ready, '0);
    model_clear();
    cyc = 0;
    while (ready !== 1'b1 && cyc < 400) begin
      // ignored requests and a re-flush attempt while flushing
      req_valid  = (cyc >= 5 && cyc < 9);
      req_we     = 1'b1; req_way_mask = 2'b11; req_lru_we = 1'b1;
      req_wdata  = '1;   req_set = 7'(cyc);
      flush_req  = (cyc == 20);
      @(posedge clk); #1;
      cyc++;
      chk("flush_no_rvalid", rvalid, '0);
    end
    req_valid = 1'b0; req_we = 1'b0; req_way_mask = 2'b00; req_lru_we = 1'b0; flush_req = 1'b0;
    chk("flush_ready_cycles", ROW_W'(cyc), ROW_W'(SETS));
    chk("flush_done_high", flush_done, 1);
    @(posedge clk); #1;
    chk("flush_done_low", flush_done, '0);
    chk("flush_done_pulses", ROW_W'(fd_count - fd_before), ROW_W'(1));
    foreach (vecs[i]) begin
      issue(vecs[i].set, 1'b0, 2'b00, 1'b0, '0, 1'b0);
      chk($sformatf("post_flush_set%0d", vecs[i].set), rdata, '0);
    end
    issue(7'd10, 1'b0, 2'b00, 1'b0, '0, 1'b0);
    chk("post_flush_set10", rdata, '0);

    // ---------------- reset during flush ----------------
    issue(7'd50, 1'b1, 2'b11, 1'b1, rand_row(), 1'b0);
    issue(7'd1,  1'b1, 2'b01, 1'b0, rand_row(), 1'b0);
    fd_before = fd_count;
    req_valid = 1'b0; flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    repeat (40) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("midflush_rst_ready", ready, '0);
    chk("midflush_rst_rvalid", rvalid, '0);
    chk("midflush_rst_rdata", rdata, '0);
    chk("midflush_rst_flush_done", flush_done, '0);
    #20;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc = 0;
    while (ready !== 1'b1 && cyc < 400) begin
      flush_req = (cyc == 10);
      @(posedge clk); #1;
      cyc++;
    end
    flush_req = 1'b0;
    chk("reinit_ready_cycles", ROW_W'(cyc), ROW_W'(SETS));
    repeat (3) begin
      @(posedge clk); #1;
      chk("reinit_stays_ready", ready, 1);
    end
    chk("midflush_no_flush_done", ROW_W'(fd_count - fd_before), '0);
    for (int s = 0; s < SETS; s++) begin
      issue(7'(s), 1'b0, 2'b00, 1'b0, '0, 1'b0);
      chk($sformatf("reinit_zero_set%0d", s), rdata, '0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
